// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline registers: the control bundle carried
// between stages, its bubble value, and the ALU operation encodings.
package pipeline_pkg;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [3:0] alu_control;
        logic       alu_src;
    } ctrl_t;

    // A bubble must never write state or redirect fetch, so all bits are 0.
    localparam ctrl_t CTRL_NOP = '0;

    // {funct7_bit, op[2:0]} as produced by the decoder
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b1110;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0010;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/decode_execute_reg.sv
// Decode-to-execute pipeline register with stall, flush (bubble insertion)
// and a saturating count of squashed instructions.
module decode_execute_reg
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallE,
    input  logic                  FlushE,

    input  logic                  ValidD,
    input  logic                  RegWriteD,
    input  logic                  MemWriteD,
    input  logic                  JumpD,
    input  logic                  BranchD,
    input  logic                  ALUSrcD,
    input  logic [1:0]            ResultSrcD,
    input  logic [3:0]            ALUControlD,
    input  logic [DATA_WIDTH-1:0] RD1D,
    input  logic [DATA_WIDTH-1:0] RD2D,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic [ADDR_WIDTH-1:0] Rs1D,
    input  logic [ADDR_WIDTH-1:0] Rs2D,
    input  logic [ADDR_WIDTH-1:0] RdD,

    output logic                  ValidE,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic                  JumpE,
    output logic                  BranchE,
    output logic                  ALUSrcE,
    output logic [1:0]            ResultSrcE,
    output logic [3:0]            ALUControlE,
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] PCE,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic [DATA_WIDTH-1:0] PCPlus4E,
    output logic [ADDR_WIDTH-1:0] Rs1E,
    output logic [ADDR_WIDTH-1:0] Rs2E,
    output logic [ADDR_WIDTH-1:0] RdE,
    output logic [7:0]            FlushCountE
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]            state_q;
    ctrl_t                 ctrl_d;
    ctrl_t                 ctrl_q;
    logic [DATA_WIDTH-1:0] rd1_q;
    logic [DATA_WIDTH-1:0] rd2_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [DATA_WIDTH-1:0] pc_plus4_q;
    logic [ADDR_WIDTH-1:0] rs1_q;
    logic [ADDR_WIDTH-1:0] rs2_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  squash;

    always_comb begin
        ctrl_d             = CTRL_NOP;
        ctrl_d.reg_write   = RegWriteD;
        ctrl_d.result_src  = ResultSrcD;
        ctrl_d.mem_write   = MemWriteD;
        ctrl_d.jump        = JumpD;
        ctrl_d.branch      = BranchD;
        ctrl_d.alu_control = ALUControlD;
        ctrl_d.alu_src     = ALUSrcD;
    end

    // Flush outranks stall; zeroed indices keep the hazard unit from matching a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            ctrl_q     <= CTRL_NOP;
            rd1_q      <= '0;
            rd2_q      <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            pc_plus4_q <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else if (FlushE) begin
            state_q    <= EMPTY;
            ctrl_q     <= CTRL_NOP;
            rd1_q      <= '0;
            rd2_q      <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            pc_plus4_q <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else if (!StallE) begin
            state_q    <= ValidD ? FULL : EMPTY;
            ctrl_q     <= ValidD ? ctrl_d : CTRL_NOP;
            rd1_q      <= RD1D;
            rd2_q      <= RD2D;
            pc_q       <= PCD;
            imm_q      <= ImmExtD;
            pc_plus4_q <= PCPlus4D;
            rs1_q      <= Rs1D;
            rs2_q      <= Rs2D;
            rd_q       <= RdD;
        end
    end

    // Only a real instruction being squashed counts as a bubble.
    assign squash = FlushE && (state_q == FULL);

    sat_counter #(
        .WIDTH(8)
    ) u_flush_count (
        .clk  (clk),
        .rst  (rst),
        .inc  (squash),
        .count(FlushCountE)
    );

    assign ValidE      = (state_q == FULL);
    assign RegWriteE   = ctrl_q.reg_write;
    assign ResultSrcE  = ctrl_q.result_src;
    assign MemWriteE   = ctrl_q.mem_write;
    assign JumpE       = ctrl_q.jump;
    assign BranchE     = ctrl_q.branch;
    assign ALUControlE = ctrl_q.alu_control;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign PCE         = pc_q;
    assign ImmExtE     = imm_q;
    assign PCPlus4E    = pc_plus4_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;
    assign RdE         = rd_q;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed self-checking bench for decode_execute_reg with hand-computed
// expectations for load, stall, flush, saturation and async reset.
module tb_decode_execute_reg;

    logic        clk;
    logic        rst;
    logic        StallE;
    logic        FlushE;
    logic        ValidD;
    logic        RegWriteD;
    logic        MemWriteD;
    logic        JumpD;
    logic        BranchD;
    logic        ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [3:0]  ALUControlD;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] PCD;
    logic [31:0] ImmExtD;
    logic [31:0] PCPlus4D;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  RdD;

    logic        ValidE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic        ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] PCE;
    logic [31:0] ImmExtE;
    logic [31:0] PCPlus4E;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic [7:0]  FlushCountE;

    int checkCount = 0;
    int errorCount = 0;
    int expCount;

    decode_execute_reg #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
        .ValidD(ValidD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
        .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
        .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
        .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .FlushCountE(FlushCountE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rw, input logic mw,
                                 input logic [3:0] alu, input logic [31:0] rd1,
                                 input logic [31:0] pc, input logic [4:0] rd);
        ValidD      = v;
        RegWriteD   = rw;
        MemWriteD   = mw;
        ALUControlD = alu;
        RD1D        = rd1;
        PCD         = pc;
        PCPlus4D    = pc + 32'd4;
        RdD         = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkBubble(input string tag);
        checkOutput({tag, ".ValidE"},      ValidE,      0);
        checkOutput({tag, ".RegWriteE"},   RegWriteE,   0);
        checkOutput({tag, ".MemWriteE"},   MemWriteE,   0);
        checkOutput({tag, ".JumpE"},       JumpE,       0);
        checkOutput({tag, ".BranchE"},     BranchE,     0);
        checkOutput({tag, ".ALUSrcE"},     ALUSrcE,     0);
        checkOutput({tag, ".ResultSrcE"},  ResultSrcE,  0);
        checkOutput({tag, ".ALUControlE"}, ALUControlE, 0);
        checkOutput({tag, ".RD1E"},        RD1E,        0);
        checkOutput({tag, ".PCPlus4E"},    PCPlus4E,    0);
        checkOutput({tag, ".Rs1E"},        Rs1E,        0);
        checkOutput({tag, ".RdE"},         RdE,         0);
    endtask

    initial begin
        rst        = 1'b0;
        StallE     = 1'b0;
        FlushE     = 1'b0;
        JumpD      = 1'b1;
        BranchD    = 1'b1;
        ALUSrcD    = 1'b1;
        ResultSrcD = 2'b10;
        RD2D       = 32'hDEAD_BEEF;
        ImmExtD    = 32'h0000_0ABC;
        Rs1D       = 5'd1;
        Rs2D       = 5'd2;
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b0111, 32'h1234_5678, 32'h200, 5'd9);

        // Reset asserted between edges must clear outputs before any clock edge
        #2 rst = 1'b1;
        #1;
        checkBubble("reset_async");
        checkOutput("reset_async.FlushCountE", FlushCountE, 0);
        step();
        checkOutput("reset_held.ValidE", ValidE, 0);
        rst = 1'b0;

        // Basic load, also confirming no D-to-E combinational path
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b1000, 32'h0000_0005, 32'h100, 5'd3);
        #1;
        checkOutput("no_comb.RdE", RdE, 0);
        step();
        checkOutput("load.ValidE",      ValidE,      1);
        checkOutput("load.ALUControlE", ALUControlE, 4'b1000);
        checkOutput("load.RD1E",        RD1E,        32'h5);
        checkOutput("load.RdE",         RdE,         3);
        checkOutput("load.RegWriteE",   RegWriteE,   1);
        checkOutput("load.MemWriteE",   MemWriteE,   0);
        checkOutput("load.JumpE",       JumpE,       1);
        checkOutput("load.BranchE",     BranchE,     1);
        checkOutput("load.ALUSrcE",     ALUSrcE,     1);
        checkOutput("load.ResultSrcE",  ResultSrcE,  2'b10);
        checkOutput("load.PCE",         PCE,         32'h100);
        checkOutput("load.PCPlus4E",    PCPlus4E,    32'h104);
        checkOutput("load.RD2E",        RD2E,        32'hDEAD_BEEF);
        checkOutput("load.ImmExtE",     ImmExtE,     32'hABC);
        checkOutput("load.Rs1E",        Rs1E,        1);
        checkOutput("load.Rs2E",        Rs2E,        2);

        applyStimulus(1'b1, 1'b0, 1'b1, 4'b1110, 32'h8000_0000, 32'h104, 5'd31);
        step();
        checkOutput("sra.ALUControlE", ALUControlE, 4'b1110);
        checkOutput("sra.RdE",         RdE,         31);
        checkOutput("sra.MemWriteE",   MemWriteE,   1);

        // Stall holds RdE=3 while decode presents RdD=7
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 32'h33, 32'h300, 5'd3);
        step();
        StallE = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 4'b0100, 32'h77, 32'h700, 5'd7);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("stall%0d.RdE", i),  RdE,  3);
            checkOutput($sformatf("stall%0d.RD1E", i), RD1E, 32'h33);
            checkOutput($sformatf("stall%0d.RegWriteE", i), RegWriteE, 1);
        end
        checkOutput("stall.FlushCountE", FlushCountE, 0);
        StallE = 1'b0;
        step();
        checkOutput("unstall.RdE",      RdE,      7);
        checkOutput("unstall.RD1E",     RD1E,     32'h77);
        checkOutput("unstall.MemWriteE", MemWriteE, 1);

        // Flush beats stall on a FULL stage with RegWriteE=1
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0011, 32'h44, 32'h400, 5'd12);
        step();
        checkOutput("pre_flush.RegWriteE", RegWriteE, 1);
        StallE = 1'b1;
        FlushE = 1'b1;
        step();
        checkBubble("flush_prio");
        checkOutput("flush_prio.FlushCountE", FlushCountE, 1);

        // Flushing an EMPTY stage is not a squash
        StallE = 1'b0;
        step();
        checkOutput("flush_empty.FlushCountE", FlushCountE, 1);
        FlushE = 1'b0;

        // Invalid instruction: controls dropped, datapath captured
        applyStimulus(1'b0, 1'b1, 1'b1, 4'b1000, 32'h55, 32'h40, 5'd6);
        step();
        checkOutput("invalid.ValidE",      ValidE,      0);
        checkOutput("invalid.RegWriteE",   RegWriteE,   0);
        checkOutput("invalid.MemWriteE",   MemWriteE,   0);
        checkOutput("invalid.JumpE",       JumpE,       0);
        checkOutput("invalid.ALUControlE", ALUControlE, 0);
        checkOutput("invalid.PCE",         PCE,         32'h40);
        checkOutput("invalid.RD1E",        RD1E,        32'h55);

        // Stall from EMPTY keeps EMPTY even with a valid instruction waiting
        StallE = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 32'h66, 32'h600, 5'd8);
        step();
        checkOutput("stall_empty.ValidE", ValidE, 0);
        checkOutput("stall_empty.PCE",    PCE,    32'h40);
        StallE = 1'b0;

        // Saturation: 300 squashes of real instructions from a count of 1
        expCount = 1;
        for (int i = 0; i < 300; i++) begin
            FlushE = 1'b0;
            applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, i, 32'h800, 5'd4);
            step();
            FlushE = 1'b1;
            step();
            if (expCount < 255) expCount++;
            if (i == 100 || i == 253 || i == 254)
                checkOutput($sformatf("sat_iter%0d.FlushCountE", i), FlushCountE, expCount);
        end
        checkOutput("sat_end.FlushCountE", FlushCountE, 255);
        step();
        checkOutput("sat_empty.FlushCountE", FlushCountE, 255);
        FlushE = 1'b0;
        step();
        FlushE = 1'b1;
        step();
        checkOutput("sat_hold.FlushCountE", FlushCountE, 255);
        FlushE = 1'b0;

        // Async reset on FULL stage, mid-stall and mid-flush
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b0010, 32'h99, 32'h900, 5'd10);
        step();
        checkOutput("pre_reset.ValidE", ValidE, 1);
        StallE = 1'b1;
        FlushE = 1'b1;
        #2 rst = 1'b1;
        #1;
        checkBubble("mid_reset");
        checkOutput("mid_reset.FlushCountE", FlushCountE, 0);
        checkOutput("mid_reset.PCE",         PCE,         0);
        step();
        StallE = 1'b0;
        FlushE = 1'b0;
        rst    = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0101, 32'hAA, 32'hA00, 5'd11);
        step();
        checkOutput("post_reset.ValidE",      ValidE,      1);
        checkOutput("post_reset.ALUControlE", ALUControlE, 4'b0101);
        checkOutput("post_reset.RdE",         RdE,         11);
        checkOutput("post_reset.FlushCountE", FlushCountE, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/decode_execute_reg.md
DECODE_EXECUTE_REG -- requirements
Module: decode_execute_reg

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of data, PC and immediate fields.
REQ-002 Parameter ADDR_WIDTH, default 5, width of register-index fields.
REQ-003 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Port StallE  in  1  hold: E outputs keep current values.
REQ-006 Port FlushE  in  1  bubble: load NOP-equivalent control on next edge.
REQ-007 Port ValidD/ValidE  in/out  1  stage holds a real instruction.
REQ-008 Ports RegWriteD/E, MemWriteD/E, JumpD/E, BranchD/E, ALUSrcD/E  in/out  1 each  control bits.
REQ-009 Ports ResultSrcD/E  in/out  2  writeback mux select.
REQ-010 Ports ALUControlD/E  in/out  4  ALU operation, {funct7_bit, op[2:0]} encoding from decode.
REQ-011 Ports RD1D/E, RD2D/E, PCD/E, ImmExtD/E, PCPlus4D/E  in/out  DATA_WIDTH  datapath operands.
REQ-012 Ports Rs1D/E, Rs2D/E, RdD/E  in/out  ADDR_WIDTH  register indices for forwarding/hazard logic.
REQ-013 Port FlushCountE  out  8  saturating count of bubbles inserted since reset.

Function
REQ-014 Every E output except FlushCountE SHALL be a register updated only on rising clk edge; no combinational D-to-E path.
REQ-015 Normal (StallE=0, FlushE=0): every E field SHALL equal its D input one cycle later; latency exactly 1 cycle.
REQ-016 Stall (StallE=1, FlushE=0): all E fields SHALL hold their previous values; FlushCountE unchanged.
REQ-017 Flush (FlushE=1): ValidE, RegWriteE, MemWriteE, JumpE, BranchE SHALL become 0; ResultSrcE, ALUControlE, ALUSrcE SHALL become 0.
REQ-018 Flush: datapath and index fields (RD1E..PCPlus4E, Rs1E, Rs2E, RdE) SHALL become 0 so hazard unit sees x0, never a false match.
REQ-019 FlushE and StallE both 1: flush SHALL win.
REQ-020 FlushCountE SHALL increment by 1 on each edge with FlushE=1 and ValidE=1 (real instruction squashed), saturating at 255.
REQ-021 ValidD=0 with StallE=0, FlushE=0: ValidE SHALL be 0 and all control bits forced 0 as per REQ-017; datapath fields still captured.
REQ-022 Stage SHALL have two states, EMPTY (ValidE=0) and FULL (ValidE=1); EMPTY->FULL on load with ValidD=1; FULL->EMPTY on flush or load with ValidD=0; stall keeps state.
REQ-023 ALUControlE SHALL be passed unmodified (no re-decoding); values 4'b1000 (SUB) and 4'b1110 (SRA) SHALL survive intact.

Reset
REQ-024 rst=1 SHALL immediately, without clk, drive all E outputs and FlushCountE to 0 (EMPTY state).
REQ-025 rst asserted mid-stall or mid-flush SHALL override both; first edge after deassertion behaves per REQ-015..REQ-019.

Structure
REQ-026 Control-bundle struct (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc) and NOP control constant SHALL live in shared package pipeline_pkg, reused by all pipeline registers.
REQ-027 ALUControl encodings (ADD 4'b0000, SUB 4'b1000, SLL 4'b0001, SLT 4'b0101, SLTU 4'b0111, XOR 4'b0100, SRL 4'b0110, SRA 4'b1110, OR 4'b0011, AND 4'b0010) SHALL be pipeline_pkg constants.
REQ-028 One sub-module, sat_counter (8-bit saturating, async reset), SHALL implement FlushCountE; remainder is flat.

Verification
REQ-029 Load: ValidD=1, ALUControlD=4'b1000, RD1D=32'h0000_0005, RdD=5'd3 -> next edge ValidE=1, ALUControlE=4'b1000, RD1E=32'h5, RdE=3.
REQ-030 Stall: FULL with RdE=3, StallE=1 three cycles while RdD=7 -> RdE stays 3 all three cycles, loads 7 on first edge after StallE=0.
REQ-031 Flush priority: FULL, RegWriteE=1, StallE=1 and FlushE=1 same edge -> ValidE=0, RegWriteE=0, RdE=0, FlushCountE=1.
REQ-032 Saturation: 300 flushes of valid instructions -> FlushCountE=255, stays 255; flush while EMPTY does not increment.
REQ-033 Async reset: FULL, assert rst between edges -> all E outputs 0 before next edge; deassert, load ValidD=1 -> ValidE=1 next edge.
REQ-034 Invalid load: ValidD=0, RegWriteD=1, MemWriteD=1, PCD=32'h40 -> ValidE=0, RegWriteE=0, MemWriteE=0, PCE=32'h40.
